// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART byte receiver.
// The FSM enum gains a PARITY state when PARITY_CHECK_EN is defined.
package uart_rx_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

`ifdef PARITY_CHECK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_e;
`endif

endpackage

// File: rtl/byte_fifo.sv
// First-word fall-through byte FIFO.
// A push into a full FIFO only succeeds when a pop happens in the same cycle.
module byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem_q [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic        overflow_q, overflow_d;
    logic        full, push_ok, pop_ok;

    always_comb begin
        level      = wr_q - rd_q;
        full       = (level == (AW+1)'(DEPTH));
        empty      = (level == '0);
        pop_ok     = pop && !empty;
        push_ok    = push && (!full || pop_ok);
        wr_d       = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d       = pop_ok ? rd_q + 1'b1 : rd_q;
        overflow_d = push && full && !pop_ok;
    end

    assign rdata    = mem_q[rd_q[AW-1:0]];
    assign overflow = overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            overflow_q <= overflow_d;
            if (push_ok) mem_q[wr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 16x-oversampled UART receiver feeding a valid/ready byte FIFO.
// Define PARITY_CHECK_EN for 8E1 framing; default build is 8N1.
module uart_byte_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     rx,
    output logic [7:0]               m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     frame_err,
    output logic                     parity_err,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    rx_state_e   state_q, state_d;
    logic        sync1_q, rx_s_q, rx_prev_q;
    logic [11:0] div_q, div_d;
    logic [3:0]  smp_q, smp_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        frame_err_q, frame_err_d;
    logic        tick, mid, bit_end, push, empty;
`ifdef PARITY_CHECK_EN
    logic        par_bad_q, par_bad_d;
    logic        parity_err_q, parity_err_d;
`endif

    always_comb begin
        tick    = (state_q != IDLE) && (div_q == 12'(CLK_DIV - 1));
        mid     = tick && (smp_q == 4'(MID_SAMPLE));
        bit_end = tick && (smp_q == 4'(OVERSAMPLE - 1));
        div_d   = (state_q == IDLE || tick) ? '0 : div_q + 1'b1;
        state_d     = state_q;
        smp_d       = tick ? smp_q + 1'b1 : smp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
`ifdef PARITY_CHECK_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                smp_d = '0;
                if (ena && rx_prev_q && !rx_s_q) state_d = START;
            end
            START: if (mid) begin
                // After the start mid-point every later sample lands on smp_q wrapping 15->0.
                smp_d   = '0;
                bit_d   = '0;
                state_d = rx_s_q ? IDLE : DATA;
`ifdef PARITY_CHECK_EN
                par_bad_d = 1'b0;
`endif
            end
            DATA: if (bit_end) begin
                shift_d = {rx_s_q, shift_q[7:1]};
                bit_d   = bit_q + 1'b1;
                if (bit_q == 3'd7) begin
`ifdef PARITY_CHECK_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: if (bit_end) begin
                par_bad_d = (rx_s_q != ^shift_q);
                state_d   = STOP;
            end
`endif
            STOP: if (bit_end) begin
                state_d     = IDLE;
                frame_err_d = !rx_s_q;
`ifdef PARITY_CHECK_EN
                parity_err_d = par_bad_q;
                push         = rx_s_q && !par_bad_q;
`else
                push         = rx_s_q;
`endif
            end
            default: state_d = IDLE;
        endcase
        if (!ena) begin
            state_d     = IDLE;
            push        = 1'b0;
            frame_err_d = 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= IDLE;
            div_q       <= '0;
            smp_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            state_q     <= state_d;
            div_q       <= div_d;
            smp_q       <= smp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef PARITY_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign frame_err = frame_err_q;
    assign m_valid   = !empty;

    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wdata    (shift_q),
        .pop      (m_ready),
        .rdata    (m_data),
        .empty    (empty),
        .level    (fifo_level),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomized self-checking bench for uart_byte_rx against a frame-level model.
module tb_uart_byte_rx;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
    localparam int BIT     = 16 * CLK_DIV;
`ifdef PARITY_CHECK_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    // 2 sync flops + edge register, 8 ticks to start mid-bit, then one bit period per later bit.
    localparam int LAT = 3 + 8 * CLK_DIV + NB * BIT;

    logic       clk = 0, rst_n = 0, ena = 1, rx = 1, m_ready = 0;
    logic [7:0] m_data;
    logic       m_valid, frame_err, parity_err, overflow;
    logic [$clog2(DEPTH):0] fifo_level;

    uart_byte_rx #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .frame_err(frame_err), .parity_err(parity_err),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int nvec = 0, nerr = 0, cyc = 0;
    int fe_cnt = 0, pe_cnt = 0, ovf_cnt = 0, vhi_cnt = 0, ovf_cyc = 0, rise_cyc = 0;
    int fe_b, pe_b, ovf_b, vhi_b, got_b;
    logic mv_prev = 0;
    logic [7:0] got_q[$];
    logic [7:0] mdl_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err)  fe_cnt++;
            if (parity_err) pe_cnt++;
            if (overflow) begin ovf_cnt++; ovf_cyc = cyc; end
            if (m_valid) vhi_cnt++;
            if (m_valid && !mv_prev) rise_cyc = cyc;
            if (m_valid && m_ready) got_q.push_back(m_data);
        end
        mv_prev = rst_n && m_valid;
    end

    task automatic clr();
        fe_b = fe_cnt; pe_b = pe_cnt; ovf_b = ovf_cnt; vhi_b = vhi_cnt; got_b = got_q.size();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        idle(BIT);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input logic par_v);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef PARITY_CHECK_EN
        drive_bit(par_v);
`else
        if (par_v === 1'bx) rx = 1'b1;
`endif
        drive_bit(stop_v);
        rx = 1'b1;
    endtask

    // Model of the FIFO: a bounded queue; returns 1 when the byte would overflow.
    function automatic bit mdl_push(input logic [7:0] b);
        if (mdl_q.size() >= DEPTH) return 1'b1;
        mdl_q.push_back(b);
        return 1'b0;
    endfunction

    task automatic test_reset();
        nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
        nvec++; if (m_data !== 8'h00) begin nerr++; $display("FAIL reset_m_data got %h exp 00", m_data); end
        nvec++; if (fifo_level !== '0) begin nerr++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
        nvec++; if ({frame_err, parity_err, overflow} !== 3'b000) begin
            nerr++; $display("FAIL reset_pulses got %b exp 000", {frame_err, parity_err, overflow}); end
    endtask

    task automatic test_basic();
        int t0;
        clr(); m_ready = 1; t0 = cyc;
        send_byte(8'hA5, 1'b1, ^8'hA5);
        idle(20);
        nvec++; if (rise_cyc - t0 !== LAT) begin nerr++; $display("FAIL basic_latency got %0d exp %0d", rise_cyc - t0, LAT); end
        nvec++; if (got_q.size() - got_b !== 1 || got_q[got_b] !== 8'hA5) begin
            nerr++; $display("FAIL basic_data got n=%0d exp 1 byte A5", got_q.size() - got_b); end
        nvec++; if (vhi_cnt - vhi_b !== 1) begin nerr++; $display("FAIL basic_valid_width got %0d exp 1", vhi_cnt - vhi_b); end
        nvec++; if (fe_cnt - fe_b !== 0 || m_valid !== 1'b0) begin
            nerr++; $display("FAIL basic_after got fe=%0d valid=%b exp 0 0", fe_cnt - fe_b, m_valid); end
    endtask

    task automatic test_glitch();
        clr();
        rx = 0; idle(20); rx = 1; idle(LAT + 50);
        nvec++; if (got_q.size() - got_b !== 0 || vhi_cnt - vhi_b !== 0) begin
            nerr++; $display("FAIL glitch_valid got pops=%0d exp 0", got_q.size() - got_b); end
        nvec++; if (fe_cnt - fe_b + pe_cnt - pe_b + ovf_cnt - ovf_b !== 0) begin
            nerr++; $display("FAIL glitch_pulses got %0d exp 0", fe_cnt - fe_b + pe_cnt - pe_b); end
    endtask

    task automatic test_frame_err();
        clr();
        send_byte(8'h3C, 1'b0, ^8'h3C);
        idle(20);
        nvec++; if (fe_cnt - fe_b !== 1) begin nerr++; $display("FAIL frame_err_count got %0d exp 1", fe_cnt - fe_b); end
        nvec++; if (fifo_level !== '0 || got_q.size() !== got_b) begin
            nerr++; $display("FAIL frame_err_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_overflow();
        int t5 = 0, exp_ovf = 0;
        clr(); m_ready = 0; mdl_q.delete();
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) t5 = cyc;
            send_byte(8'(k), 1'b1, ^(8'(k)));
            if (mdl_push(8'(k))) exp_ovf++;
        end
        idle(10);
        nvec++; if (fifo_level !== ($clog2(DEPTH)+1)'(mdl_q.size())) begin
            nerr++; $display("FAIL ovf_level got %0d exp %0d", fifo_level, mdl_q.size()); end
        nvec++; if (ovf_cnt - ovf_b !== exp_ovf) begin nerr++; $display("FAIL ovf_count got %0d exp %0d", ovf_cnt - ovf_b, exp_ovf); end
        nvec++; if (ovf_cyc - t5 !== LAT) begin nerr++; $display("FAIL ovf_timing got %0d exp %0d", ovf_cyc - t5, LAT); end
        nvec++; if (m_data !== mdl_q[0]) begin nerr++; $display("FAIL ovf_head got %h exp %h", m_data, mdl_q[0]); end
    endtask

    task automatic test_full_pop();
        clr();
        fork
            send_byte(8'h06, 1'b1, ^8'h06);
            begin idle(LAT - 1); m_ready = 1; idle(1); m_ready = 0; end
        join
        void'(mdl_q.pop_front());
        void'(mdl_push(8'h06));
        idle(10);
        nvec++; if (ovf_cnt - ovf_b !== 0) begin nerr++; $display("FAIL fullpop_ovf got %0d exp 0", ovf_cnt - ovf_b); end
        nvec++; if (fifo_level !== ($clog2(DEPTH)+1)'(mdl_q.size())) begin
            nerr++; $display("FAIL fullpop_level got %0d exp %0d", fifo_level, mdl_q.size()); end
        nvec++; if (got_q.size() - got_b !== 1 || got_q[got_b] !== 8'h01) begin
            nerr++; $display("FAIL fullpop_popped got n=%0d exp 1 byte 01", got_q.size() - got_b); end
        clr(); m_ready = 1; idle(10);
        nvec++; if (got_q.size() - got_b !== mdl_q.size()) begin
            nerr++; $display("FAIL drain_count got %0d exp %0d", got_q.size() - got_b, mdl_q.size()); end
        for (int k = 0; k < mdl_q.size() && got_b + k < got_q.size(); k++) begin
            nvec++; if (got_q[got_b + k] !== mdl_q[k]) begin
                nerr++; $display("FAIL drain_order[%0d] got %h exp %h", k, got_q[got_b + k], mdl_q[k]); end
        end
        mdl_q.delete();
    endtask

    task automatic test_reset_ena();
        m_ready = 0;
        send_byte(8'h11, 1'b1, ^8'h11);
        fork
            send_byte(8'h22, 1'b1, ^8'h22);
            begin
                idle(200); rst_n = 0; #1;
                nvec++; if ({m_valid, m_data, fifo_level, frame_err, overflow, parity_err} !== '0) begin
                    nerr++; $display("FAIL rst_mid_frame got valid=%b data=%h level=%0d exp all 0", m_valid, m_data, fifo_level); end
            end
        join
        idle(2); rst_n = 1; idle(5);
        clr(); m_ready = 1;
        send_byte(8'h5A, 1'b1, ^8'h5A); idle(20);
        nvec++; if (got_q.size() - got_b !== 1 || got_q[got_b] !== 8'h5A) begin
            nerr++; $display("FAIL rst_recover got n=%0d exp 1 byte 5A", got_q.size() - got_b); end
        m_ready = 0;
        send_byte(8'h44, 1'b1, ^8'h44);
        clr();
        fork
            send_byte(8'h5A, 1'b1, ^8'h5A);
            begin idle(200); ena = 0; idle(5); m_ready = 1; end
        join
        idle(LAT); ena = 1; idle(10);
        nvec++; if (got_q.size() - got_b !== 1 || got_q[got_b] !== 8'h44) begin
            nerr++; $display("FAIL ena_drop got n=%0d exp 1 byte 44", got_q.size() - got_b); end
        nvec++; if (fifo_level !== '0 || fe_cnt !== fe_b) begin
            nerr++; $display("FAIL ena_level got %0d exp 0", fifo_level); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        int exp_fe = 0;
        bit done = 0;
        clr();
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    logic [7:0] b = 8'($urandom);
                    logic good = ($urandom_range(4) != 0);
                    send_byte(b, good, ^b);
                    if (good) exp_q.push_back(b); else exp_fe++;
                    idle($urandom_range(30, 2));
                end
                done = 1;
            end
            while (!done) begin m_ready = 1'($urandom); idle(1); end
        join
        m_ready = 1; idle(20);
        nvec++; if (fe_cnt - fe_b !== exp_fe) begin nerr++; $display("FAIL rand_frame_err got %0d exp %0d", fe_cnt - fe_b, exp_fe); end
        nvec++; if (got_q.size() - got_b !== exp_q.size()) begin
            nerr++; $display("FAIL rand_count got %0d exp %0d", got_q.size() - got_b, exp_q.size()); end
        for (int k = 0; k < exp_q.size() && got_b + k < got_q.size(); k++) begin
            nvec++; if (got_q[got_b + k] !== exp_q[k]) begin
                nerr++; $display("FAIL rand_data[%0d] got %h exp %h", k, got_q[got_b + k], exp_q[k]); end
        end
    endtask

`ifdef PARITY_CHECK_EN
    task automatic test_parity();
        clr(); m_ready = 1;
        send_byte(8'h07, 1'b1, 1'b1); idle(20);
        nvec++; if (got_q.size() - got_b !== 1 || pe_cnt !== pe_b) begin
            nerr++; $display("FAIL parity_ok got pops=%0d perr=%0d exp 1 0", got_q.size() - got_b, pe_cnt - pe_b); end
        clr();
        send_byte(8'h07, 1'b1, 1'b0); idle(20);
        nvec++; if (got_q.size() - got_b !== 0 || pe_cnt - pe_b !== 1 || fe_cnt !== fe_b) begin
            nerr++; $display("FAIL parity_bad got pops=%0d perr=%0d exp 0 1", got_q.size() - got_b, pe_cnt - pe_b); end
        clr();
        send_byte(8'h07, 1'b0, 1'b0); idle(20);
        nvec++; if (pe_cnt - pe_b !== 1 || fe_cnt - fe_b !== 1 || got_q.size() !== got_b) begin
            nerr++; $display("FAIL parity_and_frame got perr=%0d ferr=%0d exp 1 1", pe_cnt - pe_b, fe_cnt - fe_b); end
    endtask
`endif

    initial begin
        idle(3);
        test_reset();
        rst_n = 1; idle(5);
        test_basic();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_full_pop();
        test_reset_ena();
        test_random();
`ifdef PARITY_CHECK_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
